// File: rtl/timer_ctrl_pkg.sv
// Shared types for the microwave countdown sequencer.
// States, BCD digit type and the tens-digit ceiling.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t TENS_MAX = 4'd5;

  function automatic bcd_t sat_tens(bcd_t d);
    return (d > TENS_MAX) ? TENS_MAX : d;
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Keypad/command strobes and the seconds-tens stage link.
// door_closed exists only with TIMER_DOOR_INTERLOCK_EN.
interface timer_ctrl_if;
  import timer_ctrl_pkg::*;

`ifdef TIMER_DOOR_INTERLOCK_EN
  logic door_closed;
`endif
  bcd_t key;
  logic key_valid;
  logic start;
  logic stop;
  logic cancel;
  logic tens_tc;
  logic tens_zero;
  bcd_t sec_ones;
  bcd_t minutes;
  bcd_t tens_data;
  logic tens_loadn;
  logic tens_en;
  logic running;
  logic done;

  modport master (
`ifdef TIMER_DOOR_INTERLOCK_EN
    output door_closed,
`endif
    output key,
    output key_valid,
    output start,
    output stop,
    output cancel,
    output tens_tc,
    output tens_zero,
    input  sec_ones,
    input  minutes,
    input  tens_data,
    input  tens_loadn,
    input  tens_en,
    input  running,
    input  done
  );

  modport slave (
`ifdef TIMER_DOOR_INTERLOCK_EN
    input  door_closed,
`endif
    input  key,
    input  key_valid,
    input  start,
    input  stop,
    input  cancel,
    input  tens_tc,
    input  tens_zero,
    output sec_ones,
    output minutes,
    output tens_data,
    output tens_loadn,
    output tens_en,
    output running,
    output done
  );

endinterface

// File: rtl/timer_ctrl_prescaler_tick.sv
// One-second time base: counts 0..TICK_DIV-1 while en,
// tick on the last count, holds when en is low.
module prescaler_tick #(
  parameter int TICK_DIV = 100
) (
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= '0;
    end else if (sclr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Microwave countdown sequencer driving the mod-6 tens stage.
// Optional door interlock: TIMER_DOOR_INTERLOCK_EN.
import timer_ctrl_pkg::*;

module timer_ctrl #(
  parameter int TICK_DIV = 100
) (
  input logic         clk,
  input logic         clrn,
  timer_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] PAUSE = ST_PAUSE;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0] state;
  bcd_t       sec_ones;
  bcd_t       minutes;
  bcd_t       tens_data;
  logic       tens_loadn;
  logic       done;
  // low two entry digits; the high digit is minutes itself
  logic [7:0] entry;

  logic door_ok;
  logic is_run;
  logic start_ok;
  logic key_ok;
  logic disp_zero;
  logic pre_en;
  logic pre_sclr;
  logic tick;
  logic finish;
  logic tens_en;
  logic do_clear;

`ifdef TIMER_DOOR_INTERLOCK_EN
  assign door_ok = bus.door_closed;
`else
  assign door_ok = 1'b1;
`endif

  assign is_run    = state == RUN;
  assign start_ok  = bus.start & door_ok;
  assign key_ok    = bus.key_valid
                   & (bus.key <= 4'd9);
  assign disp_zero = (sec_ones == 4'd0)
                   & bus.tens_zero
                   & (minutes == 4'd0);

  // higher-priority strobes freeze the time base
  assign pre_en   = is_run & ~bus.cancel
                  & ~bus.stop & door_ok;
  assign pre_sclr = (state == IDLE)
                  & ~bus.cancel & ~bus.stop
                  & start_ok & ~disp_zero;

  assign finish  = tick
                 & (sec_ones == 4'd1)
                 & bus.tens_zero
                 & (minutes == 4'd0);
  assign tens_en = tick & (sec_ones == 4'd0)
                 & ~finish;

  assign do_clear = bus.cancel
                  | ((state == PAUSE) & bus.stop);

  prescaler_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_pre (
    .clk  (clk),
    .clrn (clrn),
    .en   (pre_en),
    .sclr (pre_sclr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      sec_ones   <= '0;
      minutes    <= '0;
      tens_data  <= '0;
      tens_loadn <= 1'b1;
      done       <= 1'b0;
      entry      <= '0;
    end else begin
      tens_loadn <= 1'b1;
      done       <= finish;
      if (do_clear) begin
        state      <= IDLE;
        sec_ones   <= '0;
        minutes    <= '0;
        entry      <= '0;
        tens_data  <= '0;
        tens_loadn <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pre_sclr) begin
              state <= RUN;
            end else if (!bus.stop && !start_ok
                         && key_ok) begin
              entry      <= {entry[3:0], bus.key};
              minutes    <= entry[7:4];
              sec_ones   <= bus.key;
              tens_data  <= sat_tens(entry[3:0]);
              tens_loadn <= 1'b0;
            end
          end
          RUN: begin
            if (bus.stop || !door_ok) begin
              state <= PAUSE;
            end else if (finish) begin
              sec_ones <= '0;
              state    <= DONE;
            end else if (tick) begin
              if (sec_ones != 4'd0) begin
                sec_ones <= sec_ones - 4'd1;
              end else begin
                sec_ones <= 4'd9;
                if (bus.tens_tc)
                  minutes <= minutes - 4'd1;
              end
            end
          end
          PAUSE: begin
            if (start_ok)
              state <= RUN;
          end
          DONE: begin
            if (bus.stop || start_ok
                || bus.key_valid) begin
              state <= IDLE;
              entry <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sec_ones   = sec_ones;
  assign bus.minutes    = minutes;
  assign bus.tens_data  = tens_data;
  assign bus.tens_loadn = tens_loadn;
  assign bus.tens_en    = tens_en;
  assign bus.running    = is_run;
  assign bus.done       = done;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl with a behavioural
// mod-6 seconds-tens stage closing the borrow loop.
module tb_timer_ctrl;

  localparam int TD = 100;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  timer_ctrl_if ifc ();

  timer_ctrl #(
    .TICK_DIV(TD)
  ) u_dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifc)
  );

  // external seconds-tens stage
  logic [3:0] tens;
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      tens <= 4'd0;
    else if (!ifc.tens_loadn)
      tens <= ifc.tens_data;
    else if (ifc.tens_en)
      tens <= (tens == 4'd0) ? 4'd5 : tens - 4'd1;
  end
  assign ifc.tens_zero = tens == 4'd0;
  assign ifc.tens_tc   = (tens == 4'd0) & ifc.tens_en;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int mn;
    int sc;
    int tn;
    int edge_c;
  } tick_t;

  int    ld_q[$];
  tick_t tk_q[$];
  int    dn_q[$];

  task automatic chk(string nm, int act, int want);
    checks++;
    if (act != want) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, want);
    end
  endtask

  task automatic push_tick(int mn, int sc, int tn, int e);
    tick_t t;
    t.mn = mn;
    t.sc = sc;
    t.tn = tn;
    t.edge_c = e;
    tk_q.push_back(t);
  endtask

  // load monitor
  always @(negedge clk) begin
    if (clrn && !ifc.tens_loadn) begin
      if (ld_q.size() == 0)
        chk("load_unexpected", 1, 0);
      else
        chk("tens_data", int'(ifc.tens_data),
            ld_q.pop_front());
    end
  end

  // tens_en monitor: checks display after the tick edge
  always @(negedge clk) begin : tick_mon
    int    e;
    tick_t t;
    if (clrn && ifc.tens_en) begin
      e = cyc + 1;
      @(posedge clk);
      #1;
      if (tk_q.size() == 0) begin
        chk("tick_unexpected", 1, 0);
      end else begin
        t = tk_q.pop_front();
        chk("tick_edge", e, t.edge_c);
        chk("tick_min", int'(ifc.minutes), t.mn);
        chk("tick_sec", int'(ifc.sec_ones), t.sc);
        chk("tick_tens", int'(tens), t.tn);
      end
    end
  end

  // done monitor
  always @(negedge clk) begin
    if (clrn && ifc.done) begin
      if (dn_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        chk("done_edge", cyc, dn_q.pop_front());
        chk("done_sec", int'(ifc.sec_ones), 0);
        chk("done_min", int'(ifc.minutes), 0);
      end
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key_in(int k, int ld);
    if (ld >= 0) ld_q.push_back(ld);
    ifc.key       = 4'(k);
    ifc.key_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.key_valid = 1'b0;
  endtask

  task automatic pulse(bit st, bit sp, bit cn);
    ifc.start  = st;
    ifc.stop   = sp;
    ifc.cancel = cn;
    @(posedge clk);
    #1;
    ifc.start  = 1'b0;
    ifc.stop   = 1'b0;
    ifc.cancel = 1'b0;
  endtask

  task automatic cancel_c();
    ld_q.push_back(0);
    pulse(1'b0, 1'b0, 1'b1);
    wait_cyc(2);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_sec"}, int'(ifc.sec_ones), 0);
    chk({tag, "_min"}, int'(ifc.minutes), 0);
    chk({tag, "_data"}, int'(ifc.tens_data), 0);
    chk({tag, "_loadn"}, int'(ifc.tens_loadn), 1);
    chk({tag, "_en"}, int'(ifc.tens_en), 0);
    chk({tag, "_run"}, int'(ifc.running), 0);
    chk({tag, "_done"}, int'(ifc.done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    int s;
    int p;
    ifc.key       = 4'd0;
    ifc.key_valid = 1'b0;
    ifc.start     = 1'b0;
    ifc.stop      = 1'b0;
    ifc.cancel    = 1'b0;
`ifdef TIMER_DOOR_INTERLOCK_EN
    ifc.door_closed = 1'b1;
`endif
    clrn = 1'b0;
    wait_cyc(3);
    chk_reset("rst");
    clrn = 1'b1;
    wait_cyc(2);
    chk_reset("post_rst");

    // 1:30 -> first tick borrows from tens: 1:29
    key_in(1, 0);
    key_in(3, 1);
    key_in(0, 3);
    wait_cyc(1);
    chk("t1_min", int'(ifc.minutes), 1);
    chk("t1_sec", int'(ifc.sec_ones), 0);
    chk("t1_tens", int'(tens), 3);
    pulse(1'b1, 1'b0, 1'b0);
    s = cyc;
    push_tick(1, 9, 2, s + TD);
    chk("t1_run", int'(ifc.running), 1);
    wait_cyc(TD + 5);
    cancel_c();

    // 0:01 -> done one cycle after the first tick
    key_in(0, 0);
    key_in(0, 0);
    key_in(1, 0);
    pulse(1'b1, 1'b0, 1'b0);
    s = cyc;
    dn_q.push_back(s + TD);
    wait_cyc(TD + 3);
    chk("t2_run", int'(ifc.running), 0);
    chk("t2_sec", int'(ifc.sec_ones), 0);
    key_in(4, -1);
    chk("t2_exit_sec", int'(ifc.sec_ones), 0);
    key_in(7, 0);
    chk("t2_k7_sec", int'(ifc.sec_ones), 7);
    chk("t2_k7_min", int'(ifc.minutes), 0);
    cancel_c();

    // 1:00 with tens at 0 -> borrow into minutes
    key_in(1, 0);
    key_in(0, 1);
    key_in(0, 0);
    wait_cyc(1);
    chk("t3_tens", int'(tens), 0);
    chk("t3_min", int'(ifc.minutes), 1);
    pulse(1'b1, 1'b0, 1'b0);
    s = cyc;
    push_tick(0, 9, 5, s + TD);
    wait_cyc(TD + 5);
    pulse(1'b0, 1'b1, 1'b0);
    chk("t3_pause_run", int'(ifc.running), 0);
    chk("t3_pause_sec", int'(ifc.sec_ones), 9);
    ld_q.push_back(0);
    pulse(1'b0, 1'b1, 1'b0);
    wait_cyc(1);
    chk("t3_clr_sec", int'(ifc.sec_ones), 0);
    chk("t3_clr_min", int'(ifc.minutes), 0);
    wait_cyc(2);

    // tens saturates at 5; invalid key ignored
    key_in(8, 0);
    key_in(2, 5);
    key_in(12, -1);
    chk("t4_sec", int'(ifc.sec_ones), 2);
    cancel_c();

    // start at 0:00 is ignored
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(3);
    chk("t5_run", int'(ifc.running), 0);

    // pause at prescaler count 40, resume
    key_in(1, 0);
    key_in(0, 1);
    wait_cyc(1);
    pulse(1'b1, 1'b0, 1'b0);
    s = cyc;
    wait_cyc(40);
    pulse(1'b0, 1'b1, 1'b0);
    chk("t6_pause_run", int'(ifc.running), 0);
    wait_cyc(20);
    pulse(1'b1, 1'b0, 1'b0);
    p = cyc;
    chk("t6_resume_run", int'(ifc.running), 1);
    push_tick(0, 9, 0, p + TD - 40);
    wait_cyc(TD);

    // stop and start together in RUN -> PAUSE
    pulse(1'b1, 1'b1, 1'b0);
    chk("t7_run", int'(ifc.running), 0);
    wait_cyc(3);
    chk("t7_run_hold", int'(ifc.running), 0);
    chk("t7_sec", int'(ifc.sec_ones), 9);
    cancel_c();

    // asynchronous reset mid-count
    key_in(3, 0);
    pulse(1'b1, 1'b0, 1'b0);
    wait_cyc(30);
    chk("t8_run", int'(ifc.running), 1);
    clrn = 1'b0;
    #1;
    chk_reset("t8");
    wait_cyc(2);
    clrn = 1'b1;
    wait_cyc(TD + 20);

    chk("ld_q_left", ld_q.size(), 0);
    chk("tk_q_left", tk_q.size(), 0);
    chk("dn_q_left", dn_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Countdown sequencer for the microwave timer: captures keypad digits, generates the one-second time base, and counts down the seconds-ones and minutes digits. Sits directly upstream of the mod-6 seconds-tens stage and drives that stage's data, load and enable inputs. Consumes the tens stage's terminal-count and zero flags to borrow into minutes and to detect completion. Display range is 0:00–9:59.

## Interface
- TICK_DIV, 100, clk cycles per one-second tick, ≥2
- clk  in  1  system clock, rising edge
- clrn  in  1  asynchronous active-low reset
- key  in  4  keypad digit
- key_valid  in  1  one-cycle strobe qualifying key
- start  in  1  one-cycle strobe
- stop  in  1  one-cycle strobe
- cancel  in  1  one-cycle strobe
- tens_tc  in  1  tens stage terminal count: tens==0 and tens_en
- tens_zero  in  1  tens stage value is 0
- sec_ones  out  4  BCD seconds-ones digit
- minutes  out  4  BCD minutes digit
- tens_data  out  4  load value for the tens stage
- tens_loadn  out  1  active-low synchronous load, registered
- tens_en  out  1  tens decrement enable, combinational
- running  out  1  state==RUN
- done  out  1  one-cycle completion pulse, registered

## Operation
- Reset values:
  - state IDLE
  - sec_ones=0, minutes=0, tens_data=0
  - tens_loadn=1, tens_en=0, done=0
  - prescaler=0, entry=0
- States: IDLE, RUN, PAUSE, DONE.
- Priority when strobes coincide: cancel > stop > start > key_valid > tick.
- IDLE, key_valid with key≤9: entry (3 BCD digits) shifts left and the new key enters the low digit.
  - minutes ← old entry mid digit.
  - sec_ones ← key.
  - tens_data ← min(old entry low digit, 5), with tens_loadn=0 for one cycle.
  - key>9 is ignored.
  - key_valid in any other state is ignored.
- IDLE, start:
  - If sec_ones==0, tens_zero and minutes==0, start is ignored.
  - Otherwise the state goes to RUN and the prescaler clears.
- RUN: the prescaler counts 0..TICK_DIV-1, and tick is asserted on the count of TICK_DIV-1. On tick:
  - Finish: sec_ones==1, tens_zero and minutes==0 → sec_ones←0, state DONE, done=1 for the next cycle. tens_en is not asserted.
  - Else if sec_ones≠0: sec_ones decrements.
  - Else (sec_ones==0): sec_ones←9 and tens_en=1 in that cycle. If tens_tc, minutes decrements.
  - tens_tc with minutes==0 cannot occur, because the finish check precedes it.
- RUN, stop → PAUSE; the prescaler holds.
- PAUSE, start → RUN; the prescaler resumes.
- PAUSE, stop → clear.
- cancel (any state) → clear.
- Clear means:
  - digits and entry ← 0
  - tens_data=0 with tens_loadn=0 for one cycle
  - state IDLE
- DONE: digits hold at 0:00. Any key_valid, start or stop returns to IDLE with entry=0; that strobe is otherwise consumed.

## Timing
- tens_en is combinational: tick & RUN & sec_ones==0 & ~finish. The tens stage samples it on the same edge that updates sec_ones.
- tens_tc is sampled combinationally on that same edge.
- tens_loadn and tens_data are registered. They are valid the cycle after the key or clear strobe, and the tens stage loads at the following edge.
- The first tick after start arrives TICK_DIV cycles after the start edge.
- done goes high on the edge after the finishing tick, for exactly 1 cycle.
- Reset mid-RUN: all outputs take their reset values immediately. No done pulse is produced.

## Configuration
- TIMER_DOOR_INTERLOCK_EN defined:
  - adds input door_closed (1 bit)
  - start is ignored while door_closed=0
  - door_closed falling in RUN forces PAUSE the same cycle as a stop would
- TIMER_DOOR_INTERLOCK_EN undefined: the port is absent and behaviour is as above.

## Structure
- Shared package holds:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - BCD digit typedef (4 bits)
  - constant TENS_MAX=5
- Sub-module prescaler_tick: parameter TICK_DIV; inputs clk, clrn, en, sclr; output tick.
- Everything else is inline.

## Test plan
- Keys 1,3,0 then start → after key 3, tens loaded with 1. After key 0, minutes=1, tens loaded with 3, sec_ones=0. The first tick gives tens_en=1, sec_ones=9, display 1:29.
- Keys 0,0,1, start → done pulses exactly 1 cycle after the first tick. sec_ones=0 and state DONE.
- Entry 1:00 with the tens stage at 0, tick → tens_en=1, tens_tc=1, minutes=0, sec_ones=9.
- Key 8 followed by key 2 → tens_data=5.
- Start with display 0:00 → stays IDLE, running=0.
- RUN, stop at prescaler count 40 → PAUSE; start → first tick TICK_DIV-40 cycles later.
- Stop and start in the same cycle during RUN → PAUSE.
- Reset asserted mid-count → all outputs at reset values at once.
